ready_valid_reg_slice: RTL and testbench

// - Parametrised register slice for a valid/ready stream; selects which paths are registered: none, forward (valid/data), backward (ready), or both.
// - Sits at timing boundaries between pipeline stages or block ports; replaces ad-hoc single-purpose ready/valid register stages.
// - Lossless, in-order, full throughput in every mode; adds a synchronous flush and an occupancy flag.

---
 rtl/reg_slice_pkg.sv | 22 ++
 rtl/ready_valid_reg_slice_if.sv | 19 +
 rtl/reg_slice_skid_stage.sv | 67 ++++++
 rtl/ready_valid_reg_slice.sv | 139 +++++++++++++
 tb/tb_ready_valid_reg_slice.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_slice_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_slice_pkg
// Description : Shared constants for the ready/valid register slice.
//               MODE_* select which handshake paths the slice registers.
//               mode_is_valid() lets the top reject an unsupported MODE
//               while the design is being elaborated.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_slice_pkg;

  localparam int MODE_BYPASS   = 0;  // wires only, no state
  localparam int MODE_FORWARD  = 1;  // valid/data registered
  localparam int MODE_BACKWARD = 2;  // ready registered (skid buffer)
  localparam int MODE_FULL     = 3;  // skid stage feeding forward stage

  function automatic bit mode_is_valid(input int mode);
    return (mode >= MODE_BYPASS) && (mode <= MODE_FULL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ready_valid_reg_slice_if.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_reg_slice_if
// Description : One valid/ready stream channel.
//               master : drives valid, data; samples ready
//               slave  : samples valid, data; drives ready
// Revision    : 1.0 - initial release
// ============================================================================
interface ready_valid_reg_slice_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/reg_slice_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_slice_skid_stage
// Description : Skid buffer that registers the ready path. Zero latency,
//               one beat of storage.
// Ports       : clk, rst (sync, active-high), flush
//               in_valid_i / in_ready_o / in_data_i     upstream side
//               out_valid_o / out_ready_i / out_data_o  downstream side
//               held_next_o  next-state of the skid valid register
// Revision    : 1.0 - initial release
// ============================================================================
module reg_slice_skid_stage
  import reg_slice_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             held_next_o
);

  logic             kv_q;
  logic             kv_d;
  logic [WIDTH-1:0] kd_q;
  logic             ready_q;
  logic             w_accept;
  logic             w_kv_raw;

  // ready_q is preset during reset so the port reads 1 on the first cycle
  // after release; the rst gate keeps it low while reset is applied.
  assign in_ready_o = ready_q & ~rst;
  assign w_accept   = in_valid_i & in_ready_o;

  always_comb begin
    // A held beat drains when downstream accepts; otherwise a freshly
    // accepted beat that downstream refuses is caught in the skid.
    w_kv_raw = kv_q ? ~out_ready_i : (w_accept & ~out_ready_i);
    kv_d     = w_kv_raw & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kv_q    <= 1'b0;
      kd_q    <= '0;
      ready_q <= 1'b1;
    end else begin
      kv_q    <= kv_d;
      ready_q <= ~kv_d;
      if (!kv_q && w_kv_raw && !flush) begin
        kd_q <= in_data_i;
      end
    end
  end

  assign out_valid_o = ~rst & (kv_q | in_valid_i);
  assign out_data_o  = kv_q ? kd_q : in_data_i;
  assign held_next_o = kv_d;

endmodule
`default_nettype wire

// File: rtl/ready_valid_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : ready_valid_reg_slice
// Description : Parametrised valid/ready register slice. MODE selects
//               bypass, forward register, skid buffer, or skid->forward.
// Ports       : clk, rst (sync, active-high), flush (sync discard)
//               m     upstream channel (slave modport)
//               s     downstream channel (master modport)
//               busy  registered: at least one beat held
// Revision    : 1.0 - initial release
// ============================================================================
module ready_valid_reg_slice
  import reg_slice_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_FULL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  ready_valid_reg_slice_if.slave  m,
  ready_valid_reg_slice_if.master s,
  output logic                    busy
);

  if (!mode_is_valid(MODE)) begin : g_mode_check
    $error("ready_valid_reg_slice: unsupported MODE %0d", MODE);
  end

  case (MODE)
    MODE_FORWARD, MODE_FULL: begin : g_forward
      logic             w_in_valid;
      logic             w_in_ready;
      logic [WIDTH-1:0] w_in_data;
      logic             w_up_held_next;
      logic             w_accept;
      logic             ov_q;
      logic             ov_d;
      logic [WIDTH-1:0] od_q;
      logic             busy_q;

      if (MODE == MODE_FULL) begin : g_skid
        reg_slice_skid_stage #(
          .WIDTH (WIDTH)
        ) u_skid (
          .clk         (clk),
          .rst         (rst),
          .flush       (flush),
          .in_valid_i  (m.valid),
          .in_ready_o  (m.ready),
          .in_data_i   (m.data),
          .out_valid_o (w_in_valid),
          .out_ready_i (w_in_ready),
          .out_data_o  (w_in_data),
          .held_next_o (w_up_held_next)
        );
      end else begin : g_direct
        assign w_in_valid     = m.valid;
        assign w_in_data      = m.data;
        assign m.ready        = w_in_ready;
        assign w_up_held_next = 1'b0;
      end

      // The output register frees up in the same cycle it is drained.
      assign w_in_ready = ~rst & (~ov_q | s.ready);
      assign w_accept   = w_in_valid & w_in_ready;

      always_comb begin
        ov_d = ov_q;
        if (w_accept) begin
          ov_d = 1'b1;
        end else if (s.ready) begin
          ov_d = 1'b0;
        end
        if (flush) begin
          ov_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ov_q   <= 1'b0;
          od_q   <= '0;
          busy_q <= 1'b0;
        end else begin
          ov_q   <= ov_d;
          busy_q <= ov_d | w_up_held_next;
          if (w_accept && !flush) begin
            od_q <= w_in_data;
          end
        end
      end

      assign s.valid = ov_q & ~rst;
      assign s.data  = od_q;
      assign busy    = busy_q;
    end

    MODE_BACKWARD: begin : g_backward
      logic w_held_next;
      logic busy_q;

      reg_slice_skid_stage #(
        .WIDTH (WIDTH)
      ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid_i  (m.valid),
        .in_ready_o  (m.ready),
        .in_data_i   (m.data),
        .out_valid_o (s.valid),
        .out_ready_i (s.ready),
        .out_data_o  (s.data),
        .held_next_o (w_held_next)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          busy_q <= 1'b0;
        end else begin
          busy_q <= w_held_next;
        end
      end

      assign busy = busy_q;
    end

    // MODE_BYPASS; other values are already rejected by g_mode_check.
    default: begin : g_bypass
      assign s.valid = m.valid;
      assign s.data  = m.data;
      assign m.ready = s.ready;
      assign busy    = 1'b0;
    end
  endcase

endmodule
`default_nettype wire

// File: tb/tb_ready_valid_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_ready_valid_reg_slice
// Description : Bench for ready_valid_reg_slice. One instance per MODE runs
//               side by side; an occupancy model (beats held, in order)
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ready_valid_reg_slice;

  logic clk;
  logic rst;
  logic flush;

  logic [3:0]      mv;
  logic [3:0]      sr;
  logic [3:0][7:0] md;
  wire  [3:0]      mr;
  wire  [3:0]      sv;
  wire  [3:0]      bz;
  wire  [3:0][7:0] sd;

  int total = 0;
  int bad   = 0;

  // Reference model: beats held by each slice, oldest first.
  int         cnt [4];
  logic [7:0] st  [4][2];
  logic [3:0] p_mr, p_sv, p_bz, acc, dly;
  logic [7:0] p_sd [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ready_valid_reg_slice_if #(.WIDTH(8)) u_m ();
    ready_valid_reg_slice_if #(.WIDTH(8)) u_s ();

    assign u_m.valid = mv[g];
    assign u_m.data  = md[g];
    assign u_s.ready = sr[g];
    assign mr[g]     = u_m.ready;
    assign sv[g]     = u_s.valid;
    assign sd[g]     = u_s.data;

    ready_valid_reg_slice #(.WIDTH(8), .MODE(g)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .m     (u_m),
      .s     (u_s),
      .busy  (bz[g])
    );
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Outputs follow from occupancy alone: a forward register is full when
  // anything is held, a skid blocks upstream when holding, the two-stage
  // slice blocks only at two beats.
  function automatic void predict();
    for (int g = 0; g < 4; g++) begin
      p_bz[g] = (g != 0) && (cnt[g] > 0);
      p_sd[g] = (cnt[g] > 0) ? st[g][0] : md[g];
      case (g)
        0:       begin p_mr[g] = sr[g];                   p_sv[g] = mv[g]; end
        1:       begin p_mr[g] = (cnt[g] == 0) || sr[g];  p_sv[g] = cnt[g] > 0; end
        2:       begin p_mr[g] = (cnt[g] == 0);           p_sv[g] = (cnt[g] > 0) || mv[g]; end
        default: begin p_mr[g] = (cnt[g] < 2);            p_sv[g] = cnt[g] > 0; end
      endcase
      if (g != 0 && rst) begin
        p_mr[g] = 1'b0;
        p_sv[g] = 1'b0;
      end
    end
  endfunction

  task automatic mid_check();
    @(negedge clk);
    predict();
    for (int g = 0; g < 4; g++) begin
      check($sformatf("mode%0d_m_ready", g), {7'd0, mr[g]}, {7'd0, p_mr[g]});
      check($sformatf("mode%0d_s_valid", g), {7'd0, sv[g]}, {7'd0, p_sv[g]});
      if (p_sv[g]) check($sformatf("mode%0d_s_data", g), sd[g], p_sd[g]);
      check($sformatf("mode%0d_busy", g), {7'd0, bz[g]}, {7'd0, p_bz[g]});
    end
  endtask

  task automatic advance();
    logic [3:0] shs;
    predict();
    acc = mv & p_mr;
    shs = p_sv & sr;
    dly = shs;
    @(posedge clk);
    for (int g = 1; g < 4; g++) begin
      if (rst) begin
        cnt[g] = 0;
      end else begin
        if (acc[g] && cnt[g] < 2) begin
          st[g][cnt[g]] = md[g];
          cnt[g]++;
        end
        if (shs[g] && cnt[g] > 0) begin
          st[g][0] = st[g][1];
          cnt[g]--;
        end
        if (flush) cnt[g] = 0;
      end
    end
    #1;
  endtask

  task automatic idle_all();
    mv = '0;
    md = '0;
    sr = '1;
  endtask

  typedef struct {
    int         dut;
    logic       flush;
    logic       mv;
    logic [7:0] md;
    logic       sr;
    logic       e_mr;
    logic       e_sv;
    logic [7:0] e_sd;
    logic       e_bz;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int beats3;
    int cyc;
    logic [3:0] seen;
    logic       m_ready_s, s_valid_s;

    // MODE2: stream 0xA0.. with one stalled cycle downstream.
    tbl[0]  = '{2, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0};
    tbl[1]  = '{2, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0};
    tbl[2]  = '{2, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1};
    tbl[3]  = '{2, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'hA2, 1'b0};
    tbl[4]  = '{2, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b0};
    tbl[5]  = '{2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    // MODE3: fill with 0x11, 0x22 while stalled, flush, then resume.
    tbl[6]  = '{3, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{3, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    tbl[8]  = '{3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[9]  = '{3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1};
    tbl[10] = '{3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{3, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{3, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1};
    tbl[13] = '{3, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    for (int g = 0; g < 4; g++) cnt[g] = 0;
    acc = '0;
    dly = '0;
    idle_all();
    flush = 1'b0;
    rst   = 1'b1;

    // Reset: let state settle, then check it while rst is still asserted.
    repeat (2) @(posedge clk);
    #1;
    mid_check();
    advance();
    rst = 1'b0;
    mid_check();
    for (int g = 1; g < 4; g++) begin
      check($sformatf("reset_mode%0d_m_ready", g), {7'd0, mr[g]}, 8'd1);
      check($sformatf("reset_mode%0d_s_valid", g), {7'd0, sv[g]}, 8'd0);
      check($sformatf("reset_mode%0d_busy", g), {7'd0, bz[g]}, 8'd0);
    end
    check("reset_mode1_s_data", sd[1], 8'h00);
    check("reset_mode3_s_data", sd[3], 8'h00);
    advance();

    // Table vectors.
    for (int r = 0; r < 14; r++) begin
      idle_all();
      mv[tbl[r].dut] = tbl[r].mv;
      md[tbl[r].dut] = tbl[r].md;
      sr[tbl[r].dut] = tbl[r].sr;
      flush          = tbl[r].flush;
      mid_check();
      check($sformatf("vec%0d_m_ready", r), {7'd0, mr[tbl[r].dut]}, {7'd0, tbl[r].e_mr});
      check($sformatf("vec%0d_s_valid", r), {7'd0, sv[tbl[r].dut]}, {7'd0, tbl[r].e_sv});
      if (tbl[r].e_sv) check($sformatf("vec%0d_s_data", r), sd[tbl[r].dut], tbl[r].e_sd);
      check($sformatf("vec%0d_busy", r), {7'd0, bz[tbl[r].dut]}, {7'd0, tbl[r].e_bz});
      advance();
    end
    flush = 1'b0;

    // MODE1: 16 back-to-back beats, each visible one cycle after entry.
    for (int i = 0; i < 18; i++) begin
      idle_all();
      mv[1] = (i < 16);
      md[1] = 8'(i + 1);
      mid_check();
      check($sformatf("fwd_burst%0d_m_ready", i), {7'd0, mr[1]}, 8'd1);
      check($sformatf("fwd_burst%0d_s_valid", i), {7'd0, sv[1]}, {7'd0, (i >= 1 && i <= 16)});
      if (i >= 1 && i <= 16) check($sformatf("fwd_burst%0d_s_data", i), sd[1], 8'(i));
      advance();
    end

    // Random traffic on every mode; upstream holds a beat until accepted.
    idle_all();
    acc    = '0;
    beats3 = 0;
    cyc    = 0;
    while (beats3 < 1000 && cyc < 20000) begin
      for (int g = 0; g < 4; g++) begin
        if (!(mv[g] && !acc[g])) begin
          mv[g] = ($urandom_range(3) != 0);
          md[g] = 8'($urandom);
        end
        sr[g] = 1'($urandom_range(1));
      end
      flush = ($urandom_range(99) == 0);
      mid_check();
      // MODE3 outputs are registered: flipping s_ready mid-cycle must not
      // move them before the edge.
      m_ready_s = p_mr[3];
      s_valid_s = p_sv[3];
      sr[3] = ~sr[3];
      #1;
      check("full_sready_toggle_m_ready", {7'd0, mr[3]}, {7'd0, m_ready_s});
      check("full_sready_toggle_s_valid", {7'd0, sv[3]}, {7'd0, s_valid_s});
      sr[3] = ~sr[3];
      advance();
      if (dly[3]) beats3++;
      cyc++;
    end
    check("full_random_beats_done", {7'd0, (beats3 >= 1000)}, 8'd1);
    flush = 1'b0;

    // Reset with beats in flight: nothing stale may come out afterwards.
    idle_all();
    for (int g = 1; g < 4; g++) begin
      mv[g] = 1'b1;
      md[g] = 8'h5A;
      sr[g] = 1'b0;
    end
    repeat (3) begin
      mid_check();
      advance();
    end
    rst = 1'b1;
    for (int g = 1; g < 4; g++) md[g] = 8'hEE;
    repeat (2) begin
      mid_check();
      for (int g = 1; g < 4; g++) begin
        check($sformatf("in_rst_mode%0d_s_valid", g), {7'd0, sv[g]}, 8'd0);
        check($sformatf("in_rst_mode%0d_m_ready", g), {7'd0, mr[g]}, 8'd0);
      end
      advance();
    end
    rst  = 1'b0;
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      for (int g = 1; g < 4; g++) begin
        mv[g] = (i == 0);
        md[g] = (i == 0) ? 8'h77 : 8'h00;
        sr[g] = 1'b1;
      end
      mid_check();
      for (int g = 1; g < 4; g++) begin
        if (i == 0) check($sformatf("post_rst_mode%0d_m_ready", g), {7'd0, mr[g]}, 8'd1);
        if (!seen[g] && sv[g]) begin
          seen[g] = 1'b1;
          check($sformatf("post_rst_mode%0d_first_beat", g), sd[g], 8'h77);
        end
      end
      advance();
    end
    for (int g = 1; g < 4; g++) begin
      check($sformatf("post_rst_mode%0d_beat_seen", g), {7'd0, seen[g]}, 8'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
